// File: rtl/lockin_ui.sv
// rtl/lockin_ui.sv - lock-in amplifier front panel: button-edited HC word, 4-bit HD44780 LCD, status LED
// Buttons step/reset HC; the LCD shows "HC=xxxx" and is refreshed whenever HC changes.
module lockin_ui #(
  parameter logic [15:0] HC_INIT  = 16'd1000,
  parameter int          DEBOUNCE = 4,
  parameter int          T_PWRUP  = 750000,
  parameter int          T_INIT   = 205000,
  parameter int          T_CMD    = 2000,
  parameter int          T_CLEAR  = 82000,
  parameter int          T_E      = 12,
  parameter int          T_GAP    = 50
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  Button,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_E,
  output logic [3:0]  SF_D,
  output logic [15:0] HC,
  output logic        R,
  output logic        G,
  output logic        B
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_CMD, IDLE, REFRESH_ADDR, REFRESH_CHAR} state_t;
  typedef enum logic [2:0] {SP_SETUP, SP_PULSE, SP_HOLD, SP_GAP, SP_WAIT} sub_t;

  logic [3:0]    sync1, sync2, deb, deb_prev, press;
  logic [CW-1:0] cnt [4];
  logic [1:0]    step_sel, sel_next;
  logic [15:0]   step, hc_next;
  logic          hc_changed;

  state_t        state, state_n;
  sub_t          sub, sub_n;
  logic [19:0]   timer, timer_n, post_wait;
  logic [2:0]    idx, idx_n;
  logic          low_nib, low_n, pending, pending_n, byte_done, init_done;
  logic [15:0]   hc_lat, hc_lat_n;
  logic [7:0]    cur_byte;
  logic [3:0]    nibble;
  logic          cur_rs, single, sending, e_c, valid_c;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1    <= 4'hF;
      sync2    <= 4'hF;
      deb      <= 4'hF;
      deb_prev <= 4'hF;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1    <= Button;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle event on a debounced falling edge; holding never re-fires.
  assign press = deb_prev & ~deb;
  assign step  = 16'd1 << {step_sel, 2'b00};

  always_comb begin
    hc_next  = HC;
    sel_next = step_sel;
    if (press[3])      hc_next  = HC_INIT;
    else if (press[0]) hc_next  = HC + step;
    else if (press[1]) hc_next  = HC - step;
    else if (press[2]) sel_next = step_sel + 2'd1;
  end

  assign hc_changed = (hc_next != HC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HC       <= HC_INIT;
      step_sel <= 2'd0;
    end else begin
      HC       <= hc_next;
      step_sel <= sel_next;
    end
  end

  always_comb begin
    cur_byte  = 8'h00;
    cur_rs    = 1'b0;
    single    = 1'b0;
    post_wait = 20'(T_CMD);
    case (state)
      INIT_NIB: begin
        cur_byte  = (idx == 3'd3) ? 8'h20 : 8'h30;
        single    = 1'b1;
        post_wait = 20'(T_INIT);
      end
      INIT_CMD: begin
        case (idx)
          3'd0:    cur_byte = 8'h28;
          3'd1:    cur_byte = 8'h06;
          3'd2:    cur_byte = 8'h0C;
          default: cur_byte = 8'h01;
        endcase
        if (idx == 3'd3) post_wait = 20'(T_CLEAR);
      end
      REFRESH_ADDR: cur_byte = 8'h80;
      REFRESH_CHAR: begin
        cur_rs = 1'b1;
        case (idx)
          3'd0:    cur_byte = 8'h48;
          3'd1:    cur_byte = 8'h43;
          3'd2:    cur_byte = 8'h3D;
          3'd3:    cur_byte = hex_char(hc_lat[15:12]);
          3'd4:    cur_byte = hex_char(hc_lat[11:8]);
          3'd5:    cur_byte = hex_char(hc_lat[7:4]);
          default: cur_byte = hex_char(hc_lat[3:0]);
        endcase
      end
      default: ;
    endcase
  end

  assign nibble  = low_nib ? cur_byte[3:0] : cur_byte[7:4];
  assign sending = state inside {INIT_NIB, INIT_CMD, REFRESH_ADDR, REFRESH_CHAR};

  always_comb begin
    state_n   = state;
    sub_n     = sub;
    timer_n   = timer;
    idx_n     = idx;
    low_n     = low_nib;
    pending_n = pending;
    hc_lat_n  = hc_lat;
    byte_done = 1'b0;
    init_done = 1'b0;
    case (state)
      PWRUP: begin
        if (timer == 20'(T_PWRUP - 1)) begin
          state_n = INIT_NIB;
          sub_n   = SP_SETUP;
          timer_n = 20'd0;
          idx_n   = 3'd0;
          low_n   = 1'b0;
        end else begin
          timer_n = timer + 20'd1;
        end
      end
      IDLE: begin
        if (pending) begin
          state_n   = REFRESH_ADDR;
          sub_n     = SP_SETUP;
          timer_n   = 20'd0;
          low_n     = 1'b0;
          hc_lat_n  = HC;
          pending_n = 1'b0;
        end
      end
      default: begin
        // Shared nibble sequencer: setup, E pulse, hold, then gap or post-byte wait.
        case (sub)
          SP_SETUP: begin
            sub_n   = SP_PULSE;
            timer_n = 20'd0;
          end
          SP_PULSE: begin
            if (timer == 20'(T_E - 1)) begin
              sub_n   = SP_HOLD;
              timer_n = 20'd0;
            end else begin
              timer_n = timer + 20'd1;
            end
          end
          SP_HOLD: begin
            sub_n   = (!single && !low_nib) ? SP_GAP : SP_WAIT;
            timer_n = 20'd0;
          end
          SP_GAP: begin
            if (timer == 20'(T_GAP - 1)) begin
              sub_n   = SP_SETUP;
              low_n   = 1'b1;
              timer_n = 20'd0;
            end else begin
              timer_n = timer + 20'd1;
            end
          end
          default: begin
            if (timer == post_wait - 20'd1) begin
              byte_done = 1'b1;
              timer_n   = 20'd0;
            end else begin
              timer_n = timer + 20'd1;
            end
          end
        endcase
        if (byte_done) begin
          sub_n = SP_SETUP;
          low_n = 1'b0;
          idx_n = idx + 3'd1;
          case (state)
            INIT_NIB: if (idx == 3'd3) begin
              state_n = INIT_CMD;
              idx_n   = 3'd0;
            end
            INIT_CMD: if (idx == 3'd3) begin
              state_n   = IDLE;
              init_done = 1'b1;
            end
            REFRESH_ADDR: begin
              state_n = REFRESH_CHAR;
              idx_n   = 3'd0;
            end
            default: if (idx == 3'd6) state_n = IDLE;
          endcase
        end
      end
    endcase
    if (init_done || hc_changed) pending_n = 1'b1;
  end

  assign e_c     = sending && (sub == SP_PULSE);
  assign valid_c = sending && (sub inside {SP_SETUP, SP_PULSE, SP_HOLD});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= PWRUP;
      sub     <= SP_SETUP;
      timer   <= 20'd0;
      idx     <= 3'd0;
      low_nib <= 1'b0;
      pending <= 1'b0;
      hc_lat  <= HC_INIT;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      SF_D    <= 4'h0;
    end else begin
      state   <= state_n;
      sub     <= sub_n;
      timer   <= timer_n;
      idx     <= idx_n;
      low_nib <= low_n;
      pending <= pending_n;
      hc_lat  <= hc_lat_n;
      LCD_E   <= e_c;
      LCD_RS  <= valid_c & cur_rs;
      SF_D    <= valid_c ? nibble : 4'h0;
    end
  end

  assign LCD_RW = 1'b0;
  assign R      = state inside {PWRUP, INIT_NIB, INIT_CMD};
  assign G      = (state == IDLE);
  assign B      = state inside {REFRESH_ADDR, REFRESH_CHAR};

endmodule

// File: tb/tb_lockin_ui.sv
// tb/tb_lockin_ui.sv - scoreboard bench for lockin_ui
// Predicted LCD nibbles are queued when buttons are driven and popped on each LCD_E rise.
module tb_lockin_ui;
  localparam int DEB = 4;
  localparam int TE  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  button = 4'hF;
  logic        lcd_rs, lcd_rw, lcd_e;
  logic [3:0]  sf_d;
  logic [15:0] hc;
  logic        r, g, b;

  lockin_ui #(
    .HC_INIT(16'd1000), .DEBOUNCE(DEB), .T_PWRUP(20), .T_INIT(10),
    .T_CMD(4), .T_CLEAR(8), .T_E(TE), .T_GAP(2)
  ) dut (
    .CLK(clk), .RST(rst), .Button(button),
    .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .SF_D(sf_d),
    .HC(hc), .R(r), .G(g), .B(b)
  );

  always #1 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [5:0]  exp_q[$];       // {during_refresh, rs, nibble}
  logic [15:0] exp_hc = 16'h03E8;
  int          exp_sel = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    logic [7:0] digits [16];
    digits = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    return digits[d];
  endfunction

  task automatic push_byte(input logic refr, input logic rs, input logic [7:0] v);
    exp_q.push_back({refr, rs, v[7:4]});
    exp_q.push_back({refr, rs, v[3:0]});
  endtask

  task automatic push_refresh(input logic [15:0] v);
    push_byte(1'b1, 1'b0, 8'h80);
    push_byte(1'b1, 1'b1, 8'h48);
    push_byte(1'b1, 1'b1, 8'h43);
    push_byte(1'b1, 1'b1, 8'h3D);
    push_byte(1'b1, 1'b1, hex_ascii(v[15:12]));
    push_byte(1'b1, 1'b1, hex_ascii(v[11:8]));
    push_byte(1'b1, 1'b1, hex_ascii(v[7:4]));
    push_byte(1'b1, 1'b1, hex_ascii(v[3:0]));
  endtask

  task automatic apply(input logic [3:0] m);
    logic [15:0] old, stp;
    old = exp_hc;
    stp = 16'd1 << (4 * exp_sel);
    if (m[3])      exp_hc = 16'h03E8;
    else if (m[0]) exp_hc = exp_hc + stp;
    else if (m[1]) exp_hc = exp_hc - stp;
    else if (m[2]) exp_sel = (exp_sel + 1) % 4;
    if (exp_hc != old) push_refresh(exp_hc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && g) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle", {31'd0, (exp_q.size() == 0 && g)}, 32'd1);
  endtask

  task automatic press(input logic [3:0] m, input int len, input bit wait_done);
    apply(m);
    button = ~m;
    repeat (len) @(negedge clk);
    button = 4'hF;
    repeat (DEB + 8) @(negedge clk);
    check("hc", hc, exp_hc);
    if (wait_done) wait_idle();
  endtask

  // LCD bus monitor: strobe timing and scoreboard pop.
  logic       e_prev = 1'b0;
  logic [4:0] prev_d = 5'd0;
  logic [4:0] cur_nib = 5'd0;
  logic [5:0] x;
  int         e_cnt = 0;

  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      check("setup", prev_d, {lcd_rs, sf_d});
      check("nib_avail", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("nib", {lcd_rs, sf_d}, x[4:0]);
        check("led", {r, g, b}, x[5] ? 3'b001 : 3'b100);
      end
      cur_nib = {lcd_rs, sf_d};
      e_cnt   = 1;
    end else if (lcd_e) begin
      e_cnt++;
    end
    if (!lcd_e && e_prev) begin
      check("e_width", e_cnt, TE);
      check("hold", {lcd_rs, sf_d}, cur_nib);
    end
    e_prev = lcd_e;
    prev_d = {lcd_rs, sf_d};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d nibbles outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hc", hc, 16'h03E8);
    check("rst_led", {r, g, b}, 3'b100);
    check("rst_e", lcd_e, 1'b0);
    check("rst_d", sf_d, 4'h0);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);

    for (int i = 0; i < 3; i++) exp_q.push_back(6'h03);
    exp_q.push_back(6'h02);
    push_byte(1'b0, 1'b0, 8'h28);
    push_byte(1'b0, 1'b0, 8'h06);
    push_byte(1'b0, 1'b0, 8'h0C);
    push_byte(1'b0, 1'b0, 8'h01);
    push_refresh(16'h03E8);
    rst = 1'b0;
    wait_idle();
    check("init_hc", hc, 16'h03E8);
    check("idle_led", {r, g, b}, 3'b010);

    // Short press on Button[1] with exact latency: 2 sync + DEB + 1.
    apply(4'b0010);
    button = 4'b1101;
    repeat (5) @(negedge clk);
    button = 4'hF;
    @(negedge clk);
    check("lat_before", hc, 16'h03E8);
    @(negedge clk);
    check("lat_after", hc, exp_hc);
    wait_idle();

    // Glitch shorter than the debounce window.
    button = 4'b1101;
    repeat (3) @(negedge clk);
    button = 4'hF;
    repeat (30) @(negedge clk);
    check("glitch", hc, exp_hc);

    // Held press, then a second press.
    press(4'b0001, 5000, 1'b1);
    press(4'b0001, 5, 1'b1);

    // Walk HC down to zero using all step sizes, then wrap.
    press(4'b1000, 5, 1'b1);
    for (int i = 0; i < 8; i++) press(4'b0010, 5, 1'b1);
    press(4'b0100, 5, 1'b1);
    for (int i = 0; i < 14; i++) press(4'b0010, 5, 1'b1);
    press(4'b0100, 5, 1'b1);
    for (int i = 0; i < 3; i++) press(4'b0010, 5, 1'b1);
    press(4'b0100, 5, 1'b1);
    press(4'b0100, 5, 1'b1);
    check("zero", hc, 16'h0000);
    press(4'b0010, 5, 1'b1);
    check("wrap_down", hc, 16'hFFFF);
    press(4'b0100, 5, 1'b1);
    press(4'b0001, 5, 1'b1);
    check("wrap_up", hc, 16'h000F);
    press(4'b1000, 5, 1'b1);
    check("preset", hc, 16'h03E8);

    // Simultaneous [0] and [1]: only +STEP.
    press(4'b0011, 5, 1'b1);
    check("simul", hc, 16'h03F8);

    // Press during a refresh forces one more refresh with the new value.
    press(4'b0001, 5, 1'b0);
    for (int n = 0; n < 200 && !b; n++) @(negedge clk);
    check("busy", b, 1'b1);
    press(4'b0010, 5, 1'b1);
    check("final_hc", hc, 16'h03F8);

    repeat (20) @(negedge clk);
    check("q_empty", exp_q.size(), 0);
    check("end_led", {r, g, b}, 3'b010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
